// File: rtl/sprite_rom_scheduler_pkg.sv
// Shared horizontal timing and sprite ROM geometry, used by the sync generator
// and the sprite ROM scheduler.
package sprite_rom_scheduler_pkg;

  localparam int H_DISPLAY   = 640;
  localparam int H_TOTAL     = 800;
  localparam int SPRITE_ROWS = 16;
  localparam int ROW_W       = $clog2(SPRITE_ROWS);

  // Wide enough for the largest supported renderer count (8).
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/sprite_rom_scheduler_rr_pick.sv
// Combinational round-robin priority encoder: first set bit of mask at or
// above start, wrapping.
module rr_pick
  import sprite_rom_scheduler_pkg::*;
#(
  parameter int NUM_SPRITES = 4
) (
  input  logic [NUM_SPRITES-1:0] mask,
  input  logic [IDX_W-1:0]       start,
  output logic [IDX_W-1:0]       winner,
  output logic                   valid
);

  logic [NUM_SPRITES-1:0] rotated;
  int                     slot;

  always_comb begin
    rotated = NUM_SPRITES'({mask, mask} >> start);
    winner  = '0;
    valid   = 1'b0;
    slot    = 0;
    // Scan downward so the bit closest to start is the one left standing.
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        slot = int'(start) + i;
        if (slot >= NUM_SPRITES) slot = slot - NUM_SPRITES;
        winner = IDX_W'(slot);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_scheduler.sv
// Shares one sprite bitmap ROM among NUM_SPRITES renderers during hblank:
// requests latched at hpos == H_DISPLAY get back-to-back round-robin slots.
module sprite_rom_scheduler
  import sprite_rom_scheduler_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SLOT_CYCLES = 4,
  parameter int H_DISPLAY   = sprite_rom_scheduler_pkg::H_DISPLAY,
  parameter int H_TOTAL     = sprite_rom_scheduler_pkg::H_TOTAL
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [9:0]                   hpos,
  input  logic [NUM_SPRITES-1:0]       req,
  input  logic [ROW_W*NUM_SPRITES-1:0] yofs_flat,
  output logic [ROW_W-1:0]             rom_addr,
  output logic [NUM_SPRITES-1:0]       grant,
  output logic                         busy,
  output logic                         line_done,
  output logic                         overrun,
  output logic                         fsm_state
);

  state_t                 state;
  logic [NUM_SPRITES-1:0] pending;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       owner;
  logic [3:0]             slot_cnt;

  logic [NUM_SPRITES-1:0] pick_mask;
  logic [IDX_W-1:0]       pick_start;
  logic [IDX_W-1:0]       pick_winner;
  logic                   pick_valid;
  logic [NUM_SPRITES-1:0] win_onehot;
  logic [ROW_W-1:0]       owner_row;
  logic [ROW_W-1:0]       win_row;
  logic                   at_latch;
  logic                   at_close;

  assign at_latch  = (hpos == 10'(H_DISPLAY));
  assign at_close  = (hpos == 10'(H_TOTAL - 1));
  assign busy      = |grant;
  assign fsm_state = state;

  // Idle picks from the live request vector; during a slot the search runs
  // over what is left after the current owner, starting just above it.
  always_comb begin
    pick_mask  = req;
    pick_start = ptr;
    if (state == GRANT) begin
      pick_mask  = pending & ~grant;
      pick_start = (int'(owner) == NUM_SPRITES - 1) ? '0 : owner + 1'b1;
    end
  end

  rr_pick #(
    .NUM_SPRITES(NUM_SPRITES)
  ) u_rr_pick (
    .mask   (pick_mask),
    .start  (pick_start),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  assign win_onehot = NUM_SPRITES'(1) << pick_winner;

  always_comb begin
    owner_row = '0;
    win_row   = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (int'(owner) == i)       owner_row = yofs_flat[ROW_W*i +: ROW_W];
      if (int'(pick_winner) == i) win_row   = yofs_flat[ROW_W*i +: ROW_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pending   <= '0;
      ptr       <= '0;
      owner     <= '0;
      slot_cnt  <= '0;
      grant     <= '0;
      rom_addr  <= '0;
      line_done <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      line_done <= 1'b0;
      overrun   <= 1'b0;
      // The priority pointer advances every line so no renderer can starve.
      if (at_latch) ptr <= (int'(ptr) == NUM_SPRITES - 1) ? '0 : ptr + 1'b1;
      case (state)
        IDLE: begin
          if (at_latch) begin
            pending <= req;
            if (pick_valid) begin
              state    <= GRANT;
              owner    <= pick_winner;
              grant    <= win_onehot;
              rom_addr <= win_row;
              slot_cnt <= 4'(SLOT_CYCLES - 1);
            end else begin
              line_done <= 1'b1;
            end
          end
        end
        GRANT: begin
          if (at_close) begin
            // hblank is over: abandon whatever is still queued this line.
            state    <= IDLE;
            pending  <= '0;
            grant    <= '0;
            rom_addr <= '0;
            slot_cnt <= '0;
            overrun  <= 1'b1;
          end else if (slot_cnt == 4'd0) begin
            pending <= pick_mask;
            if (pick_valid) begin
              owner    <= pick_winner;
              grant    <= win_onehot;
              rom_addr <= win_row;
              slot_cnt <= 4'(SLOT_CYCLES - 1);
            end else begin
              state     <= IDLE;
              grant     <= '0;
              rom_addr  <= '0;
              line_done <= 1'b1;
            end
          end else begin
            slot_cnt <= slot_cnt - 4'd1;
            rom_addr <= owner_row;
          end
        end
      endcase
    end
  end

endmodule
